// File: rtl/mem_access_pkg.sv
// Shared types and constants for the unified-memory access initiator.
// Kind codes, error codes and controller state encoding.
package mem_access_pkg;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {
      KIND_FETCH = 2'd0,
      KIND_LOAD  = 2'd1,
      KIND_STORE = 2'd2,
      KIND_RSVD  = 2'd3
   } req_kind_e;

   typedef enum logic [1:0] {
      ERR_OK         = 2'd0,
      ERR_MISALIGNED = 2'd1,
      ERR_REGION     = 2'd2,
      ERR_BAD_KIND   = 2'd3
   } resp_err_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

endpackage

// File: rtl/mem_req_check.sv
// Combinational legality check for a core memory request.
// Priority: reserved kind, then misalignment, then region violation.
module mem_req_check
   import mem_access_pkg::*;
#(
   parameter int unsigned IMEM_BYTES = 80
) (
   input  req_kind_e         kind,
   input  logic [ADDR_W-1:0] addr,
   output resp_err_e         err,
   output logic              legal
);

   // One extra bit so IMEM_BYTES may span the whole address space.
   localparam logic [ADDR_W:0] IMEM_LIM = (ADDR_W + 1)'(IMEM_BYTES);

   logic in_imem;

   assign in_imem = ({1'b0, addr} < IMEM_LIM);

   always_comb begin
      err = ERR_OK;
      if (kind == KIND_RSVD) begin
         err = ERR_BAD_KIND;
      end else if (addr[1:0] != 2'b00) begin
         err = ERR_MISALIGNED;
      end else if ((kind == KIND_FETCH && !in_imem) ||
                   (kind == KIND_STORE &&  in_imem)) begin
         err = ERR_REGION;
      end
   end

   assign legal = (err == ERR_OK);

endmodule

// File: rtl/mem_access_initiator.sv
// Initiator for the unified instruction/data BRAM: checks, issues and times
// fetch/load/store accesses. Optional display read port under DISPLAY_PORT_EN.
module mem_access_initiator
   import mem_access_pkg::*;
#(
   parameter int unsigned IMEM_BYTES   = 80,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_kind,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic [1:0]        resp_err,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_write,
   output logic              mem_read_mode,
   output logic [4:0]        mem_display_address,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef DISPLAY_PORT_EN
   ,
   input  logic              disp_req_valid,
   output logic              disp_req_ready,
   input  logic [4:0]        disp_addr,
   output logic [DATA_W-1:0] disp_rdata,
   output logic              disp_rdata_valid
`endif
);

   state_e            state_q, state_d;
   req_kind_e         kind_q;
   resp_err_e         err_q;
   logic [DATA_W-1:0] rdata_q;
   logic [1:0]        wait_cnt_q;
   logic              ready_q;

   resp_err_e         chk_err;
   logic              chk_legal;
   logic              accept;
   logic              last_beat;
   logic              disp_go;
   logic              disp_q;

   mem_req_check #(
      .IMEM_BYTES (IMEM_BYTES)
   ) u_check (
      .kind  (req_kind_e'(req_kind)),
      .addr  (req_addr),
      .err   (chk_err),
      .legal (chk_legal)
   );

   // ready_q is registered so it reads 0 during reset and rises one edge after release.
   assign req_ready = ready_q;
   assign accept    = req_valid && ready_q;

   // Final cycle before the read data is sampled: ACCESS alone, or the last WAIT.
   assign last_beat = ((state_q == ST_ACCESS) && (READ_LATENCY <= 1)) ||
                      ((state_q == ST_WAIT) && (wait_cnt_q == 2'(READ_LATENCY - 2)));

   always_comb begin
      state_d    = state_q;
      resp_valid = 1'b0;
      resp_rdata = '0;
      resp_err   = ERR_OK;
      mem_write  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = chk_legal ? ST_ACCESS : ST_RESP;
            end else if (disp_go) begin
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            state_d   = last_beat ? ST_RESP : ST_WAIT;
            mem_write = (kind_q == KIND_STORE);
         end
         ST_WAIT: begin
            if (last_beat) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
            if (!disp_q) begin
               resp_valid = 1'b1;
               resp_err   = err_q;
               resp_rdata = rdata_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         ready_q        <= 1'b0;
         kind_q         <= KIND_FETCH;
         err_q          <= ERR_OK;
         rdata_q        <= '0;
         wait_cnt_q     <= '0;
         mem_address    <= '0;
         mem_write_data <= '0;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d == ST_IDLE);

         if (accept) begin
            kind_q  <= req_kind_e'(req_kind);
            err_q   <= chk_err;
            rdata_q <= '0;
            // Rejected requests leave the memory-facing registers untouched.
            if (chk_legal) begin
               mem_address    <= req_addr;
               mem_write_data <= req_wdata;
            end
         end else if (disp_go) begin
            kind_q      <= KIND_LOAD;
            err_q       <= ERR_OK;
            rdata_q     <= '0;
            mem_address <= ADDR_W'(IMEM_BYTES);
         end

         if (state_q == ST_ACCESS) begin
            wait_cnt_q <= '0;
         end else if (state_q == ST_WAIT) begin
            wait_cnt_q <= wait_cnt_q + 2'd1;
         end

         if (last_beat) begin
            rdata_q <= (kind_q == KIND_STORE) ? '0 : mem_rdata;
         end
      end
   end

`ifdef DISPLAY_PORT_EN
   logic [4:0] disp_addr_q;

   // The core request always wins; display is only taken from an idle, quiet port.
   assign disp_req_ready = ready_q && !req_valid;
   assign disp_go        = disp_req_valid && ready_q && !req_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_q      <= 1'b0;
         disp_addr_q <= '0;
      end else if (accept) begin
         disp_q <= 1'b0;
      end else if (disp_go) begin
         disp_q      <= 1'b1;
         disp_addr_q <= disp_addr;
      end
   end

   assign mem_read_mode       = disp_q && (state_q != ST_IDLE);
   assign mem_display_address = mem_read_mode ? disp_addr_q : '0;
   assign disp_rdata_valid    = disp_q && (state_q == ST_RESP);
   assign disp_rdata          = disp_rdata_valid ? rdata_q : '0;
`else
   assign disp_go             = 1'b0;
   assign disp_q              = 1'b0;
   assign mem_read_mode       = 1'b0;
   assign mem_display_address = '0;
`endif

endmodule

// File: tb/tb_mem_access_initiator.sv
// Directed bench: one initiator at READ_LATENCY=1 and one at READ_LATENCY=3,
// each with its own memory model; display checks when DISPLAY_PORT_EN is set.
module tb_mem_access_initiator;
   import mem_access_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tb_init;
   logic [1:0]  req_kind;
   logic [9:0]  req_addr;
   logic [31:0] req_wdata;

   logic        valid1, ready1, rv1, we1, rm1;
   logic [31:0] rd1, wd1, mrd1;
   logic [1:0]  err1;
   logic [9:0]  a1;
   logic [4:0]  da1;

   logic        valid3, ready3, rv3, we3, rm3;
   logic [31:0] rd3, wd3, mrd3;
   logic [1:0]  err3;
   logic [9:0]  a3;
   logic [4:0]  da3;

   logic [31:0] mem1 [0:255];
   logic [31:0] mem3 [0:255];
   logic [31:0] pipe3 [0:1];

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   logic [9:0]  last_addr1 = '0;

`ifdef DISPLAY_PORT_EN
   logic        dv1, dready1, drv1;
   logic [4:0]  daddr1;
   logic [31:0] drd1;
   logic        dready3, drv3;
   logic [31:0] drd3;
`endif

   always #5 clk = ~clk;

   mem_access_initiator #(.IMEM_BYTES(80), .READ_LATENCY(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(valid1), .req_ready(ready1),
      .req_kind(req_kind), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(rv1), .resp_rdata(rd1), .resp_err(err1),
      .mem_address(a1), .mem_write_data(wd1), .mem_write(we1),
      .mem_read_mode(rm1), .mem_display_address(da1), .mem_rdata(mrd1)
`ifdef DISPLAY_PORT_EN
      , .disp_req_valid(dv1), .disp_req_ready(dready1), .disp_addr(daddr1),
      .disp_rdata(drd1), .disp_rdata_valid(drv1)
`endif
   );

   mem_access_initiator #(.IMEM_BYTES(80), .READ_LATENCY(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .req_valid(valid3), .req_ready(ready3),
      .req_kind(req_kind), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(rv3), .resp_rdata(rd3), .resp_err(err3),
      .mem_address(a3), .mem_write_data(wd3), .mem_write(we3),
      .mem_read_mode(rm3), .mem_display_address(da3), .mem_rdata(mrd3)
`ifdef DISPLAY_PORT_EN
      , .disp_req_valid(1'b0), .disp_req_ready(dready3), .disp_addr(5'd0),
      .disp_rdata(drd3), .disp_rdata_valid(drv3)
`endif
   );

   // Latency-1 memory reads combinationally; latency-3 memory has two register stages.
   assign mrd1 = mem1[a1[9:2]];
   assign mrd3 = pipe3[1];

   always @(posedge clk) begin
      if (tb_init) begin
         for (int i = 0; i < 256; i++) begin
            mem1[i] <= {16'hA5A5, 16'(i)};
            mem3[i] <= {16'hA5A5, 16'(i)};
         end
         mem1[0]   <= 32'h8C22_0050;
         mem3[255] <= 32'hCAFE_F00D;
      end else begin
         if (we1) mem1[a1[9:2]] <= wd1;
         if (we3) mem3[a3[9:2]] <= wd3;
      end
      pipe3[0] <= mem3[a3[9:2]];
      pipe3[1] <= pipe3[0];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full request on the latency-1 instance with per-cycle timing checks.
   task automatic req1(input logic [1:0] kind, input logic [9:0] addr, input logic [31:0] wdata,
                       input logic [1:0] exp_err, input logic [31:0] exp_rdata, input string tag);
      check({tag, "_ready0"}, 32'(ready1), 32'd1);
      valid1 = 1'b1; req_kind = kind; req_addr = addr; req_wdata = wdata;
      tick();
      valid1 = 1'b0;
      check({tag, "_busy"}, 32'(ready1), 32'd0);
      if (exp_err != 2'd0) begin
         check({tag, "_rv"},    32'(rv1),  32'd1);
         check({tag, "_err"},   32'(err1), 32'(exp_err));
         check({tag, "_rdata"}, rd1,       32'd0);
         check({tag, "_nowr"},  32'(we1),  32'd0);
         check({tag, "_addr"},  32'(a1),   32'(last_addr1));
      end else begin
         last_addr1 = addr;
         check({tag, "_rv_acc"}, 32'(rv1), 32'd0);
         check({tag, "_we"},     32'(we1), 32'(kind == KIND_STORE));
         check({tag, "_addr"},   32'(a1),  32'(addr));
         if (kind == KIND_STORE) check({tag, "_wdata"}, wd1, wdata);
         tick();
         check({tag, "_rv"},    32'(rv1),  32'd1);
         check({tag, "_err"},   32'(err1), 32'd0);
         check({tag, "_rdata"}, rd1,       exp_rdata);
         check({tag, "_we_off"}, 32'(we1), 32'd0);
      end
      tick();
      check({tag, "_rv_off"},  32'(rv1),    32'd0);
      check({tag, "_ready1"},  32'(ready1), 32'd1);
   endtask

   // Legal request on the latency-3 instance: response in cycle 4, ready in cycle 5.
   task automatic req3(input logic [1:0] kind, input logic [9:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input string tag);
      check({tag, "_ready0"}, 32'(ready3), 32'd1);
      valid3 = 1'b1; req_kind = kind; req_addr = addr; req_wdata = wdata;
      tick();
      valid3 = 1'b0;
      check({tag, "_addr"}, 32'(a3),  32'(addr));
      check({tag, "_we"},   32'(we3), 32'(kind == KIND_STORE));
      for (int c = 1; c <= 3; c++) begin
         if (c > 1) begin
            tick();
            check({tag, "_we_wait"}, 32'(we3), 32'd0);
         end
         check({tag, "_busy"},  32'(ready3), 32'd0);
         check({tag, "_rv_lo"}, 32'(rv3),    32'd0);
      end
      tick();
      check({tag, "_rv"},    32'(rv3),    32'd1);
      check({tag, "_err"},   32'(err3),   32'd0);
      check({tag, "_rdata"}, rd3,         exp_rdata);
      check({tag, "_busy4"}, 32'(ready3), 32'd0);
      tick();
      check({tag, "_rv_off"}, 32'(rv3),    32'd0);
      check({tag, "_ready5"}, 32'(ready3), 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; tb_init = 1'b1;
      valid1 = 1'b0; valid3 = 1'b0;
      req_kind = 2'd0; req_addr = '0; req_wdata = '0;
`ifdef DISPLAY_PORT_EN
      dv1 = 1'b0; daddr1 = 5'd0;
`endif
      #1;
      check("rst_ready",  32'(ready1), 32'd0);
      check("rst_rv",     32'(rv1),    32'd0);
      check("rst_we",     32'(we1),    32'd0);
      check("rst_addr",   32'(a1),     32'd0);
      check("rst_rdata",  rd1,         32'd0);
      check("rst_err",    32'(err1),   32'd0);
      check("rst_rmode",  32'(rm1),    32'd0);
      check("rst_daddr",  32'(da1),    32'd0);
      tick();
      tick();
      tb_init = 1'b0;
      rst_n   = 1'b1;
      tick();

      req1(KIND_FETCH, 10'd0,     32'h0,         2'd0, 32'h8C22_0050, "fetch0");
      req1(KIND_STORE, 10'd84,    32'hDEAD_BEEF, 2'd0, 32'h0,         "store84");
      req1(KIND_LOAD,  10'd84,    32'h0,         2'd0, 32'hDEAD_BEEF, "load84");
      req1(KIND_FETCH, 10'd80,    32'h0,         2'd2, 32'h0,         "fetch80");
      req1(KIND_STORE, 10'd76,    32'h1111_1111, 2'd2, 32'h0,         "store76");
      req1(KIND_LOAD,  10'h052,   32'h0,         2'd1, 32'h0,         "load52");
      req1(KIND_RSVD,  10'h040,   32'h0,         2'd3, 32'h0,         "kind3");
      req1(KIND_RSVD,  10'h053,   32'h0,         2'd3, 32'h0,         "kind3_mis");
      req1(KIND_FETCH, 10'h051,   32'h0,         2'd1, 32'h0,         "fetch51");
      req1(KIND_FETCH, 10'd76,    32'h0,         2'd0, 32'hA5A5_0013, "fetch76");
      req1(KIND_STORE, 10'd80,    32'h1234_5678, 2'd0, 32'h0,         "store80");
      req1(KIND_LOAD,  10'd80,    32'h0,         2'd0, 32'h1234_5678, "load80");
      req1(KIND_LOAD,  10'd1020,  32'h0,         2'd0, 32'hA5A5_00FF, "load1020");
      req1(KIND_LOAD,  10'd4,     32'h0,         2'd0, 32'hA5A5_0001, "load4");

      req3(KIND_LOAD,  10'd1020, 32'h0,         32'hCAFE_F00D, "rl3_load1020");
      req3(KIND_STORE, 10'd100,  32'hDEAD_BEEF, 32'h0,         "rl3_store100");
      req3(KIND_LOAD,  10'd100,  32'h0,         32'hDEAD_BEEF, "rl3_load100");

      // Reset asserted while the latency-3 instance sits in WAIT.
      valid3 = 1'b1; req_kind = KIND_LOAD; req_addr = 10'd1020;
      tick();
      valid3 = 1'b0;
      tick();
      #2 rst_n = 1'b0;
      #1;
      check("arst_ready", 32'(ready3), 32'd0);
      check("arst_rv",    32'(rv3),    32'd0);
      check("arst_addr",  32'(a3),     32'd0);
      check("arst_wdata", wd3,         32'd0);
      check("arst_we",    32'(we3),    32'd0);
      check("arst_rdata", rd3,         32'd0);
      tick();
      rst_n = 1'b1;
      check("arst_hold_rv", 32'(rv3), 32'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         check("arst_no_resp", 32'(rv3), 32'd0);
      end
      req3(KIND_LOAD, 10'd84, 32'h0, 32'hA5A5_0015, "rl3_after_rst");

`ifdef DISPLAY_PORT_EN
      // Display and core requests together: core first, display next.
      last_addr1 = 10'd84;
      dv1 = 1'b1; daddr1 = 5'd1;
      valid1 = 1'b1; req_kind = KIND_LOAD; req_addr = 10'd84;
      #1;
      check("disp_blocked", 32'(dready1), 32'd0);
      tick();
      valid1 = 1'b0;
      check("disp_core_addr",  32'(a1),  32'd84);
      check("disp_core_rmode", 32'(rm1), 32'd0);
      tick();
      check("disp_core_rv",    32'(rv1), 32'd1);
      check("disp_core_rdata", rd1,      32'hDEAD_BEEF);
      tick();
      check("disp_ready",      32'(dready1), 32'd1);
      tick();
      dv1 = 1'b0;
      check("disp_rmode",  32'(rm1), 32'd1);
      check("disp_daddr",  32'(da1), 32'd1);
      check("disp_addr80", 32'(a1),  32'd80);
      check("disp_no_we",  32'(we1), 32'd0);
      tick();
      check("disp_rv",     32'(drv1), 32'd1);
      check("disp_rdata",  drd1,      32'h1234_5678);
      check("disp_no_core_rv", 32'(rv1), 32'd0);
      tick();
      check("disp_rv_off", 32'(drv1), 32'd0);
      check("disp_rmode0", 32'(rm1),  32'd0);
      check("disp_idle",   32'(ready1), 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_access_initiator.md
Name: mem_access_initiator

Overview:
- Initiator side of the unified instruction/data memory used by the multicycle core.
- Accepts fetch, load and store requests from the core control FSM over a valid/ready handshake.
- Checks each request for legality, drives the memory's address/writeData/MemWrite inputs, waits out the synchronous BRAM read latency, and returns one response pulse carrying read data or an error code.
- Sits between the control FSM and the memory, replacing direct FSM-to-memory wiring.

Parameters:
- IMEM_BYTES, 80: instruction region spans [0, IMEM_BYTES); data region spans [IMEM_BYTES, 1024). Must be a multiple of 4.
- READ_LATENCY, 1: edges from memory sampling its address to read data being valid. Legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_kind  in  2  0=FETCH, 1=LOAD, 2=STORE, 3=reserved.
- req_addr  in  10  byte address.
- req_wdata  in  32  store data, big-endian byte order.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  read word; 0 for stores and errors.
- resp_err  out  2  0=OK, 1=MISALIGNED, 2=REGION, 3=BAD_KIND.
- mem_address  out  10  to memory address.
- mem_write_data  out  32  to memory writeData.
- mem_write  out  1  to memory MemWrite.
- mem_read_mode  out  1  to memory readMode.
- mem_display_address  out  5  to memory displayAddress.
- mem_rdata  in  32  from the memory's muxed instruction output.

Behaviour:
- Reset: all outputs 0, including req_ready; state IDLE. Reset is asynchronous: it kills any in-flight access, drops mem_write immediately and emits no response.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- Accept: a request is accepted at edge E when req_valid and req_ready are both high. Kind, address and wdata are registered at E.
- Legality check, in priority order:
  - kind==3 → BAD_KIND.
  - addr[1:0]!=0 → MISALIGNED.
  - FETCH with addr>=IMEM_BYTES, or STORE with addr<IMEM_BYTES → REGION.
  - LOAD is legal in both regions.
- Error path: IDLE→RESP. No memory signal changes; mem_write stays 0. resp_valid is high in cycle E+1 with resp_err set and resp_rdata=0.
- Legal path: IDLE→ACCESS (1 cycle) → WAIT (READ_LATENCY-1 cycles; skipped when READ_LATENCY=1) → RESP.
  - mem_address and mem_write_data are driven from cycle E+1.
  - mem_write=1 only in the ACCESS cycle, and only for STORE.
  - mem_rdata is captured on the edge leaving the final ACCESS/WAIT cycle.
  - resp_valid is high in cycle E+1+READ_LATENCY.
  - STORE returns resp_rdata=0 with the same timing.
- RESP→IDLE unconditionally. req_ready returns in cycle E+2+READ_LATENCY. The response path has no backpressure.
- mem_address and mem_write_data hold their last value after an access so the BRAM output stays stable. mem_read_mode=0 and mem_display_address=0 outside display accesses.
- Boundary cases:
  - addr 1020 is the last legal word.
  - addr IMEM_BYTES-4 is the last FETCH word.
  - addr IMEM_BYTES is the first STORE word.
  - req_valid deasserted mid-transaction has no effect; the request is already registered.

Optional Feature:
- Macro: DISPLAY_PORT_EN.
- Enabled: extra ports disp_req_valid (in, 1), disp_req_ready (out, 1), disp_addr (in, 5), disp_rdata (out, 32), disp_rdata_valid (out, 1).
  - A display request is served from IDLE only when req_valid is low; the core always wins.
  - While serving it: mem_read_mode=1, mem_display_address=disp_addr, and mem_address is held at IMEM_BYTES so the data region is enabled.
  - Latency equals the legal-path latency; disp_rdata_valid pulses in cycle E+1+READ_LATENCY.
- Disabled: these ports are absent and mem_read_mode and mem_display_address are constant 0.

Decomposition:
- Package mem_access_pkg: kind codes, error codes, FSM state enum, ADDR_W=10, DATA_W=32.
- Sub-module mem_req_check: purely combinational; takes kind, addr and IMEM_BYTES, and produces err code and a legal flag.

Test Plan:
- FETCH addr 0x000 with the instruction word at that address = 0x8C220050 → ACCESS in cycle 1, resp_valid in cycle 2, resp_rdata=0x8C220050, err 0.
- STORE addr 84, wdata 0xDEADBEEF, then LOAD addr 84 → mem_write high for exactly 1 cycle with mem_address=84; the load returns 0xDEADBEEF.
- FETCH 80 → err 2 with no mem_write. STORE 76 → err 2 with no mem_write. LOAD 0x052 → err 1. Kind 3 → err 3. Each error response arrives in cycle E+1.
- READ_LATENCY=3: LOAD 1020 → resp_valid in cycle 4, resp_rdata = word at 1020; req_ready low during cycles 1..4 and high in cycle 5.
- rst_n asserted during WAIT → all outputs 0 asynchronously, no resp_valid; a new request after release completes normally.
- DISPLAY_PORT_EN: disp_req with disp_addr 1 together with req_valid → core served first; display served next with mem_read_mode=1, mem_display_address=1, mem_address=80.
